decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 instr  in  16  instruction from fetch, aligned with PC in the same cycle.
REQ-004 PC  in  16  address of instr.
REQ-005 PCPlus1  in  16  PC+1 from fetch.
REQ-006 jorb  in  1  taken jump/branch resolved downstream; flush.
REQ-007 int_ack  in  1  interrupt entry acknowledged by fetch; flush.
REQ-008 wb_en / wb_reg / wb_data  in  1/3/16  register-file write port.
REQ-009 ex_memRead / ex_rd  in  1/3  the instruction in EX is a load, and its destination register.
REQ-010 id_valid  out  1  the IF/ID latch holds a real instruction.
REQ-011 id_instr / id_PC / id_PCPlus1  out  16 each  latched fetch values.
REQ-012 rs_data / rt_data  out  16 each  register read data.
REQ-013 imm  out  16  sign-extended immediate.
REQ-014 ldStall / ldStallPC  out  1/16  load-use stall request, and the PC fetch must hold.
REQ-015 halt / haltPC  out  1/16  halt reached, and the PC of the halt instruction.

Function
REQ-016 Fields: opcode=[15:12], rd=[11:9], rs=[8:6], rt=[5:3]; imm = sign-extended [5:0] for opcode<4'h8, otherwise sign-extended [8:0].
REQ-017 IF/ID latch: each cycle it captures instr, PC and PCPlus1 and sets id_valid=1, unless held or flushed.
REQ-018 Hold: when ldStall=1 the latch keeps its contents and id_valid for the next cycle.
REQ-019 Flush: when jorb=1 or int_ack=1, the next cycle has id_valid=0 and id_instr=16'hF000 (NOP).
REQ-020 If a flush and a hold occur in the same cycle, the flush wins.
REQ-021 Register file: 8x16.
- R0 always reads 0; writes to R0 are ignored.
- The write occurs on the clock edge when wb_en=1.
REQ-022 Read bypass: if wb_en=1 and wb_reg equals a non-zero read index, that port returns wb_data in the same cycle.
REQ-023 Register use: rs is used by all opcodes except 4'h0, 4'h3 and 4'hF; rt is used only by opcodes 4'h4 to 4'h9.
REQ-024 ldStall = id_valid & ex_memRead & (ex_rd != 0) & (ex_rd matches a used rs or rt). It is combinational.
REQ-025 ldStallPC = id_PC.
REQ-026 Halt: an edge with id_valid=1 and opcode 4'h0 sets halt=1 and loads haltPC=id_PC.
- halt is sticky until rst.
- While halt=1, the latch is frozen and id_valid is forced to 0.
REQ-027 Opcode 4'h3 (interrupt return) is passed through as a normal valid instruction, with no register reads.
REQ-028 Decode outputs (imm, rs_data, rt_data) are combinational from the latch and the register file: 1-cycle latency from fetch.

Reset
REQ-029 While rst=1 at an edge, the stage clears to the following values:
- id_valid=0, id_instr=16'hF000, id_PC=0, id_PCPlus1=0.
- halt=0, haltPC=0.
- All registers = 0.
REQ-030 Reset overrides flush, hold and write-back in the same cycle; after reset, ldStall=0.

Structure
REQ-031 A shared package holds:
- opcode constants OP_HALT=4'h0, OP_RETI=4'h3, OP_LD=4'h8, OP_ST=4'h9, OP_NOP=4'hF;
- NOP_INSTR=16'hF000;
- register-index width 3.
REQ-032 One sub-module, regfile8x16 (2 read ports, 1 write port, bypass, R0=0), is instantiated once.

Verification
REQ-033 Write and bypass:
- wb_en=1, wb_reg=3, wb_data=16'hBEEF while instr reads R3 -> rs_data=16'hBEEF in that cycle.
- The following cycle, after the write, still returns 16'hBEEF.
REQ-034 Load-use stall: ex_memRead=1, ex_rd=2, latched add with rs=2, id_PC=16'h0010.
- Required: ldStall=1, ldStallPC=16'h0010, latch unchanged next cycle.
- Once ex_memRead=0, the stall clears.
REQ-035 Flush priority: jorb=1 and ldStall=1 in the same cycle -> next cycle id_valid=0, id_instr=16'hF000.
REQ-036 Halt: instr=16'h0000 at PC=16'h0007.
- One cycle after latching: halt=1, haltPC=16'h0007.
- Later instructions do not change id_valid (stays 0).
REQ-037 Reset mid-operation: rst=1 during a stall with R5=16'h1234 -> all outputs at reset values, R5 reads 0.
REQ-038 R0 write: wb_en=1, wb_reg=0, wb_data=16'hFFFF -> rs_data reading R0 = 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode values, the NOP encoding, register-index
// width and small field helpers used by the decode stage and its register file.
package decode_stage_pkg;

    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
    localparam int DATA_W    = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [3:0]           opcode_t;

    localparam opcode_t OP_HALT = 4'h0;
    localparam opcode_t OP_RETI = 4'h3;
    localparam opcode_t OP_LD   = 4'h8;
    localparam opcode_t OP_ST   = 4'h9;
    localparam opcode_t OP_NOP  = 4'hF;

    localparam word_t NOP_INSTR = 16'hF000;

    // rs is read by everything except halt, interrupt return and nop.
    function automatic logic uses_rs(input opcode_t op);
        return !(op == OP_HALT || op == OP_RETI || op == OP_NOP);
    endfunction

    // rt is only read by the register-register / load / store group 4..9.
    function automatic logic uses_rt(input opcode_t op);
        return (op >= 4'h4) && (op <= OP_ST);
    endfunction

    // Short (6-bit) immediate below the load opcode, long (9-bit) from it up.
    function automatic word_t sext_imm(input opcode_t op, input logic [8:0] raw);
        word_t r;
        if (op < OP_LD)
            r = {{10{raw[5]}}, raw[5:0]};
        else
            r = {{7{raw[8]}}, raw[8:0]};
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/write-back/execute side signals of the decode stage grouped as one bus.
// slave = decode stage side, master = the environment driving it.
interface decode_stage_if;
    import decode_stage_pkg::*;

    // from fetch
    word_t    instr;
    word_t    PC;
    word_t    PCPlus1;
    // redirect / flush sources
    logic     jorb;
    logic     int_ack;
    // register-file write port
    logic     wb_en;
    reg_idx_t wb_reg;
    word_t    wb_data;
    // load in EX, for load-use detection
    logic     ex_memRead;
    reg_idx_t ex_rd;

    // decode results
    logic     id_valid;
    word_t    id_instr;
    word_t    id_PC;
    word_t    id_PCPlus1;
    word_t    rs_data;
    word_t    rt_data;
    word_t    imm;
    logic     ldStall;
    word_t    ldStallPC;
    logic     halt;
    word_t    haltPC;

    modport slave (
        input  instr, PC, PCPlus1, jorb, int_ack,
        input  wb_en, wb_reg, wb_data, ex_memRead, ex_rd,
        output id_valid, id_instr, id_PC, id_PCPlus1,
        output rs_data, rt_data, imm, ldStall, ldStallPC, halt, haltPC
    );

    modport master (
        output instr, PC, PCPlus1, jorb, int_ack,
        output wb_en, wb_reg, wb_data, ex_memRead, ex_rd,
        input  id_valid, id_instr, id_PC, id_PCPlus1,
        input  rs_data, rt_data, imm, ldStall, ldStallPC, halt, haltPC
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// 8x16 register file: two combinational read ports with write-through bypass,
// one write port, R0 hard-wired to zero.
module regfile8x16
    import decode_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    input  reg_idx_t raddr_a,
    output word_t    rdata_a,
    input  reg_idx_t raddr_b,
    output word_t    rdata_b
);

    word_t regs [NUM_REGS];

    // Storage update; R0 is never written so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: R0 reads zero, a same-cycle write to the index is forwarded.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0)
            rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
        if (raddr_b != '0)
            rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID latch with hold/flush, register read, immediate
// extraction, load-use hazard detection and sticky halt capture.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic  id_valid_q;
    word_t id_instr_q;
    word_t id_pc_q;
    word_t id_pc_plus1_q;
    logic  halt_q;
    word_t halt_pc_q;

    opcode_t  op;
    reg_idx_t rs_idx;
    reg_idx_t rt_idx;
    logic     flush;
    logic     hazard_rs;
    logic     hazard_rt;
    logic     ld_stall;
    logic     halt_hit;

    assign op     = id_instr_q[15:12];
    assign rs_idx = id_instr_q[8:6];
    assign rt_idx = id_instr_q[5:3];
    assign flush  = bus.jorb | bus.int_ack;

    // Load-use hazard: the load in EX targets a register this instruction reads.
    always_comb begin
        hazard_rs = uses_rs(op) && (rs_idx == bus.ex_rd);
        hazard_rt = uses_rt(op) && (rt_idx == bus.ex_rd);
        ld_stall  = id_valid_q && bus.ex_memRead && (bus.ex_rd != '0)
                    && (hazard_rs || hazard_rt);
    end

    assign halt_hit = id_valid_q && (op == OP_HALT) && !halt_q;

    // Halt capture: sticky once a valid halt instruction sits in the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q    <= 1'b0;
            halt_pc_q <= '0;
        end else if (halt_hit) begin
            halt_q    <= 1'b1;
            halt_pc_q <= id_pc_q;
        end
    end

    // IF/ID latch: reset > halted freeze > flush > load-use hold > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus1_q <= '0;
        end else if (halt_q || halt_hit) begin
            // contents frozen, nothing further is issued
            id_valid_q <= 1'b0;
        end else if (flush) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= bus.PC;
            id_pc_plus1_q <= bus.PCPlus1;
        end else if (!ld_stall) begin
            id_valid_q    <= 1'b1;
            id_instr_q    <= bus.instr;
            id_pc_q       <= bus.PC;
            id_pc_plus1_q <= bus.PCPlus1;
        end
    end

    regfile8x16 u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_en),
        .waddr   (bus.wb_reg),
        .wdata   (bus.wb_data),
        .raddr_a (rs_idx),
        .rdata_a (bus.rs_data),
        .raddr_b (rt_idx),
        .rdata_b (bus.rt_data)
    );

    assign bus.imm        = sext_imm(op, id_instr_q[8:0]);
    assign bus.id_valid   = id_valid_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_PC      = id_pc_q;
    assign bus.id_PCPlus1 = id_pc_plus1_q;
    assign bus.ldStall    = ld_stall;
    assign bus.ldStallPC  = id_pc_q;
    assign bus.halt       = halt_q;
    assign bus.haltPC     = halt_pc_q;

endmodule
